// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative RV32M divider.
// Used by div_unit and div_step. The optional DIV_FASTPATH_EN build macro
// is consumed in div_unit only.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

    localparam int DIV_XLEN_DEF = 32;

    // DIV and REM interpret their operands as two's complement.
    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // REM and REMU return the remainder rather than the quotient.
    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the {rem,quo} pair left by one,
// then subtract the divisor from the partial remainder when it fits and
// record the outcome as the new quotient LSB.
module div_step
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN_DEF
) (
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shift_rem_s;
    logic [XLEN:0] trial_s;
    logic [XLEN:0] divisor_ext_s;

    // Trial subtraction on the shifted remainder; restore when it would go negative
    always_comb begin
        divisor_ext_s = {1'b0, divisor};
        shift_rem_s   = (rem << 1'b1) | {{XLEN{1'b0}}, quo[XLEN-1]};
        trial_s       = shift_rem_s - divisor_ext_s;
        if (shift_rem_s >= divisor_ext_s) begin
            rem_next = trial_s;
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shift_rem_s;
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) for the Execute stage.
// A start pulse captures operand magnitudes and sign flags, XLEN restoring
// steps run in CALC, signs and the divide-by-zero quotient are applied in
// FIX, and DONE presents the result with a one-cycle done pulse.
// Build option: define DIV_FASTPATH_EN to resolve divide-by-zero and signed
// overflow directly at start (result in the next cycle). Without it those
// operands take the normal iterative path and give identical results.
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);

    div_state_e      state_r;
    div_op_e         op_r;
    logic [XLEN:0]   rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] dsor_r;
    logic [CW-1:0]   cnt_r;
    logic            neg_quo_r;
    logic            neg_rem_r;
    logic            div_zero_r;
    logic            done_r;
    logic [XLEN-1:0] result_r;

    div_op_e         op_in_s;
    logic            in_signed_s;
    logic            dend_neg_s;
    logic            dsor_neg_s;
    logic [XLEN-1:0] dend_abs_s;
    logic [XLEN-1:0] dsor_abs_s;
    logic            fast_hit_s;
    logic [XLEN-1:0] fast_result_s;
    logic [XLEN:0]   rem_next_s;
    logic [XLEN-1:0] quo_next_s;
    logic [XLEN-1:0] rem_mag_s;
    logic [XLEN-1:0] quo_fix_s;
    logic [XLEN-1:0] rem_fix_s;
    logic [XLEN-1:0] fix_result_s;

    // Decode the incoming op and form operand magnitudes for the unsigned core
    always_comb begin
        op_in_s     = div_op_e'(i_op);
        in_signed_s = op_is_signed(op_in_s);
        dend_neg_s  = in_signed_s & i_dividend[XLEN-1];
        dsor_neg_s  = in_signed_s & i_divisor[XLEN-1];
        if (dend_neg_s) begin
            dend_abs_s = -i_dividend;
        end else begin
            dend_abs_s = i_dividend;
        end
        if (dsor_neg_s) begin
            dsor_abs_s = -i_divisor;
        end else begin
            dsor_abs_s = i_divisor;
        end
    end

`ifdef DIV_FASTPATH_EN
    // Recognise operands whose architectural result needs no iteration
    always_comb begin
        fast_hit_s    = 1'b0;
        fast_result_s = {XLEN{1'b0}};
        if (i_divisor == {XLEN{1'b0}}) begin
            fast_hit_s = 1'b1;
            if (op_is_rem(op_in_s)) begin
                fast_result_s = i_dividend;
            end else begin
                fast_result_s = {XLEN{1'b1}};
            end
        end else if (in_signed_s && (i_dividend == {1'b1, {(XLEN-1){1'b0}}})
                     && (i_divisor == {XLEN{1'b1}})) begin
            fast_hit_s = 1'b1;
            if (op_is_rem(op_in_s)) begin
                fast_result_s = {XLEN{1'b0}};
            end else begin
                fast_result_s = i_dividend;
            end
        end else begin
            fast_hit_s    = 1'b0;
            fast_result_s = {XLEN{1'b0}};
        end
    end
`else
    assign fast_hit_s    = 1'b0;
    assign fast_result_s = {XLEN{1'b0}};
`endif

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dsor_r),
        .rem_next (rem_next_s),
        .quo_next (quo_next_s)
    );

    // Restore signs and select quotient or remainder for the final result
    always_comb begin
        rem_mag_s = XLEN'(rem_r);
        if (div_zero_r) begin
            quo_fix_s = {XLEN{1'b1}};
        end else if (neg_quo_r) begin
            quo_fix_s = -quo_r;
        end else begin
            quo_fix_s = quo_r;
        end
        if (neg_rem_r) begin
            rem_fix_s = -rem_mag_s;
        end else begin
            rem_fix_s = rem_mag_s;
        end
        if (op_is_rem(op_r)) begin
            fix_result_s = rem_fix_s;
        end else begin
            fix_result_s = quo_fix_s;
        end
    end

    // Stall the pipeline from the accepted start through FIX; release in DONE
    always_comb begin
        o_stall = 1'b0;
        case (state_r)
            IDLE, DONE: o_stall = i_start;
            CALC, FIX:  o_stall = 1'b1;
            default:    o_stall = 1'b0;
        endcase
    end

    // Divider sequencer: capture, iterate, fix signs, report
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            op_r       <= OP_DIV;
            rem_r      <= {(XLEN+1){1'b0}};
            quo_r      <= {XLEN{1'b0}};
            dsor_r     <= {XLEN{1'b0}};
            cnt_r      <= {CW{1'b0}};
            neg_quo_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= {XLEN{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (i_start && fast_hit_s) begin
                        result_r <= fast_result_s;
                        done_r   <= 1'b1;
                        state_r  <= DONE;
                    end else if (i_start) begin
                        op_r       <= op_in_s;
                        rem_r      <= {(XLEN+1){1'b0}};
                        quo_r      <= dend_abs_s;
                        dsor_r     <= dsor_abs_s;
                        cnt_r      <= CW'(XLEN - 1);
                        neg_quo_r  <= dend_neg_s ^ dsor_neg_s;
                        neg_rem_r  <= dend_neg_s;
                        div_zero_r <= (i_divisor == {XLEN{1'b0}});
                        state_r    <= CALC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= FIX;
                    end else begin
                        cnt_r <= cnt_r - CW'(1'b1);
                    end
                end
                FIX: begin
                    result_r <= fix_result_s;
                    done_r   <= 1'b1;
                    state_r  <= DONE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign o_done   = done_r;
    assign o_result = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, randomized operands
// against an arithmetic reference model, start-ignore, back-to-back restart
// and mid-operation reset.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_result;

    int compared   = 0;
    int mismatched = 0;

    div_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_stall    (o_stall),
        .o_done     (o_done),
        .o_result   (o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M-extension division semantics in plain arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        logic        sgn;
        sgn = (op == 2'b00) || (op == 2'b10);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int lat_for(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        int lat;
        lat = 34;
`ifdef DIV_FASTPATH_EN
        if (b == 32'd0) lat = 1;
        if ((op == 2'b00 || op == 2'b10) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) lat = 1;
`endif
        return lat;
    endfunction

    // Drive a start pulse at the current negedge; stall must rise at once
    task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        i_op       = op;
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        #1;
        check({tag, "/stall_start"}, {31'd0, o_stall}, 32'd1);
    endtask

    // Watch cycles after a start: latency, result, hold, stall profile, pulse count
    task automatic await_done(input string tag, input logic [31:0] exp, input int lat,
                              input int inject, input bit chain, input logic [1:0] cop,
                              input logic [31:0] ca, input logic [31:0] cb);
        int dones    = 0;
        int stall_er = 0;
        int hold_er  = 0;
        for (int n = 1; n <= lat + 4; n++) begin
            @(negedge clk);
            if (n == 1 || n == inject + 1) i_start = 1'b0;
            if (n == 1) begin
                i_dividend = $urandom;
                i_divisor  = $urandom;
                i_op       = 2'($urandom);
            end
            if (n == inject) begin
                i_start    = 1'b1;
                i_dividend = $urandom;
                i_divisor  = $urandom_range(1, 9);
            end
            #1;
            if (o_done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    check({tag, "/latency"}, 32'(n), 32'(lat));
                    check({tag, "/result"}, o_result, exp);
                end
            end
            if (dones > 0 && o_result !== exp) hold_er++;
            if (o_stall !== ((dones == 0) && (n < lat))) stall_er++;
            if (chain && dones == 1) begin
                check({tag, "/stall_profile"}, 32'(stall_er), 32'd0);
                issue({tag, "/chain"}, cop, ca, cb);
                return;
            end
        end
        check({tag, "/done_count"}, 32'(dones), 32'd1);
        check({tag, "/stall_profile"}, 32'(stall_er), 32'd0);
        check({tag, "/result_hold"}, 32'(hold_er), 32'd0);
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        issue(tag, op, a, b);
        await_done(tag, exp, lat_for(op, a, b), -1, 1'b0, 2'b00, 32'd0, 32'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          dones;

        reset      = 1'b0;
        i_start    = 1'b0;
        i_op       = 2'b00;
        i_dividend = 32'd0;
        i_divisor  = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset/stall", {31'd0, o_stall}, 32'd0);
        check("reset/done", {31'd0, o_done}, 32'd0);
        check("reset/result", o_result, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases with hand-derived results
        run("div_20_3",   2'b00, 32'd20, 32'd3, 32'd6);
        run("rem_20_3",   2'b10, 32'd20, 32'd3, 32'd2);
        run("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run("divu_big_2", 2'b01, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
        run("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1);
        run("divu_x_0",   2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run("div_x_0",    2'b00, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run("remu_x_0",   2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678);
        run("div_neg_0",  2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        run("rem_neg_0",  2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
        run("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run("divu_min_1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Start pulse during CALC must be ignored
        @(negedge clk);
        issue("ignore", 2'b00, 32'd100, 32'd7);
        await_done("ignore", 32'd14, 34, 5, 1'b0, 2'b00, 32'd0, 32'd0);

        // Restart accepted in the DONE cycle
        @(negedge clk);
        issue("restart1", 2'b01, 32'd1000, 32'd10);
        await_done("restart1", 32'd100, 34, -1, 1'b1, 2'b10, 32'hFFFF_FF9C, 32'd7);
        await_done("restart2", 32'hFFFF_FFFE, 34, -1, 1'b0, 2'b00, 32'd0, 32'd0);

        // Reset in the middle of CALC
        @(negedge clk);
        issue("midreset", 2'b00, 32'h0000_1000, 32'd3);
        @(negedge clk);
        i_start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset/stall", {31'd0, o_stall}, 32'd0);
        check("midreset/result", o_result, 32'd0);
        check("midreset/done", {31'd0, o_done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            if (o_done === 1'b1) dones++;
        end
        check("midreset/no_done", 32'(dones), 32'd0);
        run("after_reset", 2'b00, 32'h0000_1000, 32'd3, 32'h0000_0555);

        // Randomized operands against the reference model
        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'hFFFF_FFFF;
                3: b = $urandom_range(1, 15);
                4: a = 32'h8000_0000;
                default: b = $urandom;
            endcase
            run($sformatf("rand%0d_op%0d", k, op), op, a, b, ref_div(op, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
